// File: rtl/smvm_stream_tx_if.sv
// Stream interface for smvm_stream_tx.
// Groups the source beat handshake (s_valid/s_data/s_ready) and the SMVM
// output stream (val_out/col_out/ipv_out).
//   master : host side, drives source beats, observes s_ready and the stream
//   slave  : transmitter side, accepts beats and drives the stream
interface smvm_stream_tx_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic [7:0] val_out;
  logic [2:0] col_out;
  logic       ipv_out;

  modport master (output s_valid, s_data,
                  input  s_ready, val_out, col_out, ipv_out);
  modport slave  (input  s_valid, s_data,
                  output s_ready, val_out, col_out, ipv_out);
endinterface

// File: rtl/smvm_stream_tx.sv
// SMVM input stream transmitter.
// Captures a shape and dense vector, compresses a dense row-major matrix
// into a nonzero buffer, then replays header, vector and nonzeros as one
// gap-free stream ending with an all-zero terminator cycle.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             one-cycle request, samples rows_in/cols_in
//   rows_in, cols_in  matrix shape (rows 1..255, cols 1..MAX_COLS)
//   bus (slave)       source beats in, val/col/ipv stream out
//   busy              high outside IDLE
//   done              pulse on the terminator cycle
//   err               sticky error, cleared by the next accepted start
//   empty_rows        all-zero rows in the last matrix (saturating)
//
// state    | meaning
// IDLE     | waiting for start
// LOAD_VEC | accepting cols vector elements
// LOAD_MAT | accepting rows*cols matrix elements, pushing nonzeros
// DRAIN    | buffer overflowed; discarding remaining matrix beats
// TX_HDR   | sending (rows, cols)
// TX_VEC   | sending vector elements
// TX_VAL   | sending nonzero value with first-in-row flag
// TX_COL   | sending column index of that nonzero, pop
// TX_END   | terminator cycle, done pulse
module smvm_stream_tx #(
  parameter int NNZ_MAX  = 64,
  parameter int MAX_COLS = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [7:0]            rows_in,
  input  logic [2:0]            cols_in,
  smvm_stream_tx_if.slave       bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            empty_rows
);

  localparam int PW = $clog2(NNZ_MAX + 1);
  localparam int AW = (NNZ_MAX > 1) ? $clog2(NNZ_MAX) : 1;

  typedef enum logic [3:0] {
    IDLE, LOAD_VEC, LOAD_MAT, DRAIN, TX_HDR, TX_VEC, TX_VAL, TX_COL, TX_END
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      rows_q, rows_d;
  logic [2:0]      cols_q, cols_d;
  // Sized to the full 3-bit index range so any idx value is in bounds.
  logic [7:0]      vec_q [8];
  logic [7:0]      vec_d [8];
  logic [2:0]      idx_q, idx_d;
  logic [2:0]      col_q, col_d;
  logic [10:0]     beats_q, beats_d;
  logic            row_nz_q, row_nz_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            err_q, err_d;
  logic [7:0]      empty_q, empty_d;

  // Entry layout: {val[7:0], col[2:0], first}
  logic [11:0]     mem_q [NNZ_MAX];
  logic            push;
  logic [11:0]     push_data;
  logic [11:0]     rd_entry;

  logic            beat;
  logic            last_beat;
  logic            row_end;
  logic            nz;
  logic            full;
  logic [PW-1:0]   rd_next;

  assign beat      = bus.s_valid & bus.s_ready;
  assign last_beat = (beats_q == 11'd1);
  assign row_end   = (col_q == cols_q - 3'd1);
  assign nz        = (bus.s_data != 8'd0);
  assign full      = (wr_ptr_q == PW'(NNZ_MAX));
  assign rd_next   = rd_ptr_q + PW'(1);
  assign rd_entry  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    vec_d     = vec_q;
    idx_d     = idx_q;
    col_d     = col_q;
    beats_d   = beats_q;
    row_nz_d  = row_nz_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    err_d     = err_q;
    empty_d   = empty_q;
    push      = 1'b0;
    push_data = {bus.s_data, col_q, ~row_nz_q};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if ((rows_in != 8'd0) && (cols_in != 3'd0) && (cols_in <= 3'(MAX_COLS))) begin
            rows_d   = rows_in;
            cols_d   = cols_in;
            err_d    = 1'b0;
            empty_d  = 8'd0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            idx_d    = 3'd0;
            state_d  = LOAD_VEC;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      LOAD_VEC: begin
        if (beat) begin
          vec_d[idx_q] = bus.s_data;
          if (idx_q == cols_q - 3'd1) begin
            idx_d    = 3'd0;
            col_d    = 3'd0;
            row_nz_d = 1'b0;
            beats_d  = 11'(rows_q) * 11'(cols_q);
            state_d  = LOAD_MAT;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end

      LOAD_MAT: begin
        if (beat) begin
          beats_d  = beats_q - 11'd1;
          col_d    = row_end ? 3'd0 : col_q + 3'd1;
          row_nz_d = row_end ? 1'b0 : (row_nz_q | nz);
          if (nz && full) begin
            // Overflow on the final beat leaves nothing to drain.
            err_d   = 1'b1;
            state_d = last_beat ? IDLE : DRAIN;
          end else begin
            if (nz) begin
              push     = 1'b1;
              wr_ptr_d = wr_ptr_q + PW'(1);
            end else if (row_end && !row_nz_q && (empty_q != 8'hFF)) begin
              empty_d = empty_q + 8'd1;
            end
            if (last_beat) state_d = TX_HDR;
          end
        end
      end

      DRAIN: begin
        if (beat) begin
          beats_d = beats_q - 11'd1;
          if (last_beat) state_d = IDLE;
        end
      end

      TX_HDR: begin
        idx_d   = 3'd0;
        state_d = TX_VEC;
      end

      TX_VEC: begin
        if (idx_q == cols_q - 3'd1) begin
          idx_d   = 3'd0;
          state_d = (wr_ptr_q == '0) ? TX_END : TX_VAL;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end

      TX_VAL: state_d = TX_COL;

      TX_COL: begin
        rd_ptr_d = rd_next;
        state_d  = (rd_next < wr_ptr_q) ? TX_VAL : TX_END;
      end

      TX_END: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rows_q   <= 8'd0;
      cols_q   <= 3'd0;
      for (int i = 0; i < 8; i++) vec_q[i] <= 8'd0;
      idx_q    <= 3'd0;
      col_q    <= 3'd0;
      beats_q  <= 11'd0;
      row_nz_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      err_q    <= 1'b0;
      empty_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      rows_q   <= rows_d;
      cols_q   <= cols_d;
      vec_q    <= vec_d;
      idx_q    <= idx_d;
      col_q    <= col_d;
      beats_q  <= beats_d;
      row_nz_q <= row_nz_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      err_q    <= err_d;
      empty_q  <= empty_d;
    end
  end

  // Buffer storage needs no reset: entries are only read below wr_ptr.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

  // Outputs decode straight from state so an async reset zeroes them at once.
  logic [7:0] val_o;
  logic [2:0] col_o;
  logic       ipv_o;

  always_comb begin
    val_o = 8'd0;
    col_o = 3'd0;
    ipv_o = 1'b0;
    unique case (state_q)
      TX_HDR: begin
        val_o = rows_q;
        col_o = cols_q;
      end
      TX_VEC: val_o = vec_q[idx_q];
      TX_VAL: begin
        val_o = rd_entry[11:4];
        ipv_o = rd_entry[0];
      end
      TX_COL: col_o = rd_entry[3:1];
      default: ;
    endcase
  end

  assign bus.val_out = val_o;
  assign bus.col_out = col_o;
  assign bus.ipv_out = ipv_o;
  assign bus.s_ready = (state_q == LOAD_VEC) || (state_q == LOAD_MAT) || (state_q == DRAIN);
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == TX_END);
  assign err         = err_q;
  assign empty_rows  = empty_q;

endmodule

// File: tb/tb_smvm_stream_tx.sv
module tb_smvm_stream_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] rows_in = 8'd0;
  logic [2:0] cols_in = 3'd0;
  logic       busy, done, err;
  logic [7:0] empty_rows;

  smvm_stream_tx_if bus();

  smvm_stream_tx #(.NNZ_MAX(4), .MAX_COLS(7)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rows_in    (rows_in),
    .cols_in    (cols_in),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .empty_rows (empty_rows)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [7:0]  beats [$];
  logic [12:0] exp_q [$];

  always @(posedge clk) if (done) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [12:0] e(input logic [7:0] v, input logic [2:0] c,
                                   input logic i, input logic d);
    return {v, c, i, d};
  endfunction

  function automatic logic [12:0] obs_stream();
    return {bus.val_out, bus.col_out, bus.ipv_out, done};
  endfunction

  task automatic do_start(input logic [7:0] r, input logic [2:0] c);
    @(negedge clk);
    start = 1'b1; rows_in = r; cols_in = c;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the last accepted beat.
  task automatic feed(input bit gaps);
    int i = 0;
    int guard = 0;
    logic v;
    while (i < beats.size()) begin
      v = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      bus.s_valid = v;
      bus.s_data  = beats[i];
      if (v && bus.s_ready) i++;
      @(negedge clk);
      guard++;
      if (guard > 2000) begin
        chk("feed_timeout", 32'd0, 32'd1);
        break;
      end
    end
    bus.s_valid = 1'b0;
    bus.s_data  = 8'd0;
  endtask

  task automatic expect_stream(input string tag);
    for (int k = 0; k < exp_q.size(); k++) begin
      chk(tag, 32'(obs_stream()), 32'(exp_q[k]));
      chk({tag, "_rdy"}, 32'(bus.s_ready), 32'd0);
      @(negedge clk);
    end
    chk({tag, "_idle"}, 32'({busy, obs_stream()}), 32'd0);
  endtask

  task automatic load_case1();
    beats = '{8'd1, 8'd2, 8'd3, 8'd0, 8'd5, 8'd0, 8'hFE, 8'd0, 8'd7};
    exp_q = '{e(8'd2,3'd3,0,0), e(8'd1,0,0,0), e(8'd2,0,0,0), e(8'd3,0,0,0),
              e(8'd5,0,1,0), e(8'd0,3'd1,0,0), e(8'hFE,0,1,0), e(8'd0,0,0,0),
              e(8'd7,0,0,0), e(8'd0,3'd2,0,0), e(8'd0,0,0,1)};
  endtask

  int d0;

  initial begin
    bus.s_valid = 1'b0;
    bus.s_data  = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_outs", 32'({busy, done, err, empty_rows, bus.s_ready, obs_stream()}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 2x3 mixed matrix
    load_case1();
    do_start(8'd2, 3'd3);
    chk("load_busy", 32'({busy, bus.s_ready}), 32'b11);
    feed(1'b0);
    expect_stream("c1");
    chk("c1_empty", 32'(empty_rows), 32'd0);
    chk("c1_err", 32'(err), 32'd0);

    // 3x2 with an empty row and a zero vector element
    beats = '{8'd4, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd9};
    exp_q = '{e(8'd3,3'd2,0,0), e(8'd4,0,0,0), e(8'd0,0,0,0),
              e(8'd1,0,1,0), e(8'd0,0,0,0), e(8'd9,0,1,0), e(8'd0,3'd1,0,0),
              e(8'd0,0,0,1)};
    do_start(8'd3, 3'd2);
    feed(1'b0);
    expect_stream("c2");
    chk("c2_empty", 32'(empty_rows), 32'd1);

    // all-zero 2x2
    beats = '{8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
    exp_q = '{e(8'd2,3'd2,0,0), e(8'd3,0,0,0), e(8'd4,0,0,0), e(8'd0,0,0,1)};
    do_start(8'd2, 3'd2);
    feed(1'b0);
    expect_stream("c3");
    chk("c3_empty", 32'(empty_rows), 32'd2);

    // case 1 again with random source stalls
    load_case1();
    do_start(8'd2, 3'd3);
    feed(1'b1);
    expect_stream("c1gap");

    // overflow: 1x7 with 5 nonzeros into a 4-entry buffer
    d0 = done_cnt;
    beats = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd1, 8'd2, 8'd3, 8'd4};
    do_start(8'd1, 3'd7);
    feed(1'b0);
    chk("ovf_pre_err", 32'({err, busy}), 32'b01);
    beats = '{8'd5, 8'd0, 8'd6};
    feed(1'b0);
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_idle", 32'(busy), 32'd0);
    for (int k = 0; k < 3; k++) begin
      chk("ovf_no_tx", 32'(obs_stream()), 32'd0);
      @(negedge clk);
    end
    chk("ovf_no_done", 32'(done_cnt), 32'(d0));

    // next legal start clears err
    beats = '{8'd3, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
    exp_q = '{e(8'd2,3'd2,0,0), e(8'd3,0,0,0), e(8'd4,0,0,0), e(8'd0,0,0,1)};
    do_start(8'd2, 3'd2);
    chk("clr_err", 32'(err), 32'd0);
    feed(1'b0);
    expect_stream("c3b");

    // illegal shapes
    do_start(8'd2, 3'd0);
    chk("bad_cols", 32'({err, busy}), 32'b10);
    do_start(8'd0, 3'd2);
    chk("bad_rows", 32'({err, busy}), 32'b10);

    // start while busy is ignored
    load_case1();
    do_start(8'd2, 3'd3);
    start = 1'b1; rows_in = 8'd9; cols_in = 3'd1;
    feed(1'b0);
    start = 1'b0;
    expect_stream("busy_start");

    // async reset during TX_VAL
    d0 = done_cnt;
    load_case1();
    do_start(8'd2, 3'd3);
    feed(1'b0);
    repeat (4) @(negedge clk);
    chk("pre_rst", 32'(obs_stream()), 32'(e(8'd5,0,1,0)));
    rst_n = 1'b0;
    #1;
    chk("rst_mid", 32'({busy, done, bus.s_ready, obs_stream()}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_no_done", 32'(done_cnt), 32'(d0));
    chk("rst_idle", 32'({busy, obs_stream()}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/smvm_stream_tx.md
Name: smvm_stream_tx

Overview:
- Host-side transmitter that produces the SMVM input stream (val/col/ipv) from a dense, row-major source.
- Captures the shape and dense vector, then compresses the dense matrix into a nonzero buffer.
- Once capture is complete, replays everything as one gap-free stream, because the receiver treats any val=0 cycle in its value phase as end-of-matrix.
- Sits between the host/testbench data source and the SMVM core's val_in/col_in/ipv_in pins.

Parameters:
NNZ_MAX, 64, depth of nonzero buffer (entries of {val[7:0], col[2:0], first})
MAX_COLS, 7, maximum column count; col field is 3 bits

Ports:
clk  input  1  clock
rst_n  input  1  reset
start  input  1  one-cycle request; samples rows_in/cols_in
rows_in  input  8  matrix rows, legal 1..255
cols_in  input  3  matrix columns = vector length, legal 1..7
s_valid  input  1  source beat valid
s_data  input  8  signed source beat: cols vector elements, then rows*cols matrix elements row-major
s_ready  output  1  source beat accepted when s_valid & s_ready
val_out  output  8  to SMVM val_in
col_out  output  3  to SMVM col_in
ipv_out  output  1  to SMVM ipv_in
busy  output  1  high outside IDLE
done  output  1  one-cycle pulse on the terminator cycle
err  output  1  sticky error, cleared by the next accepted start
empty_rows  output  8  count of all-zero rows in the last matrix

Behaviour:
- Interface (decided): one clock; reset is asynchronous and active-low.
- Reset values:
  - State IDLE.
  - All outputs 0.
  - Buffer pointers, counters and vector registers 0.
- Reset mid-operation aborts silently: no terminator, no done.
- States: IDLE, LOAD_VEC, LOAD_MAT, TX_HDR, TX_VEC, TX_VAL, TX_COL, TX_END, DRAIN.
- IDLE:
  - A start with rows_in != 0 and cols_in != 0 latches the shape, clears err, empty_rows and buffer, and goes to LOAD_VEC.
  - A start with an illegal shape sets err and stays in IDLE.
  - start outside IDLE is ignored.
- LOAD_VEC:
  - s_ready = 1.
  - Each beat goes to vec[i].
  - After cols beats, go to LOAD_MAT.
- LOAD_MAT:
  - s_ready = 1.
  - Track row and column counters.
  - Each nonzero beat pushes {s_data, col, first}; first = 1 iff this is the row's first nonzero.
  - A row ending with no nonzero increments empty_rows (saturating at 255).
  - After rows*cols beats, go to TX_HDR the next cycle.
  - A push into a full buffer (NNZ_MAX already stored) sets err and goes to DRAIN.
- DRAIN:
  - s_ready = 1.
  - Discard the remaining matrix beats, then go to IDLE.
  - No transmission and no done.
- Source stalls (s_valid = 0) are allowed during load only.
- val_out/col_out/ipv_out are 0 in every state except TX_*.
- TX_HDR (1 cycle): val_out = rows, col_out = cols, ipv_out = 0.
- TX_VEC (cols cycles): val_out = vec[i], col_out = 0, ipv_out = 0. A zero element is sent as-is.
- TX_VAL: val_out = entry.val, ipv_out = entry.first, col_out = 0.
- TX_COL: val_out = 0, col_out = entry.col, ipv_out = 0; pop the entry. Then go to TX_VAL if entries remain, else TX_END.
- nnz = 0: TX_VEC goes directly to TX_END.
- TX_END (1 cycle): all outputs 0 (terminator), done = 1, then IDLE.
- Total transmit length is 1 + cols + 2*nnz + 1 consecutive cycles, with no idle gaps.
- Buffer:
  - Written only in LOAD_MAT, read only in TX_VAL/TX_COL; no simultaneous push/pop.
  - Full = count == NNZ_MAX; empty = count == 0.
  - Pointers are reset per start.
- Arithmetic: rows*cols beat count uses a 11-bit counter. Values are passed unmodified as two's complement.

Test Plan:
- rows=2, cols=3, vec [1,2,3], matrix [[0,5,0],[-2,0,7]] -> 11 consecutive cycles: (val,col,ipv) = (2,3,0) (1,0,0) (2,0,0) (3,0,0) (5,0,1) (0,1,0) (0xFE,0,1) (0,0,0) (7,0,0) (0,2,0) (0,0,0), with done on the last cycle; empty_rows=0, err=0.
- rows=3, cols=2, vec [4,0], matrix [[1,0],[0,0],[0,9]] -> header (3,2,0), vector 4,0, then (1,0,1)(0,0,0)(9,0,1)(0,1,0), terminator; empty_rows=1.
- All-zero 2x2 matrix -> header, 2 vector cycles, terminator; 4 cycles total.
- NNZ_MAX=4, 1x7 row with 5 nonzeros -> err=1 on the 5th nonzero; remaining beats still accepted; no TX, no done; next legal start clears err.
- Random s_valid gaps during load -> output stream is identical to the gap-free case; s_ready = 0 throughout TX.
- cols_in=0 start -> err=1, busy stays 0. rst_n low during TX_VAL -> all outputs 0 immediately, state IDLE.
